// File: rtl/serial_addsub_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_unit_pkg
// Purpose  : Shared constants and types for the bit-serial add/subtract unit.
//            Provides the frame geometry, the operand width, the add/subtract
//            phase boundary and the mapping from generator position
//            (CTRL_IN_B) to frame position k.
// Revision : 1.0 - initial release
// ============================================================================
package serial_addsub_unit_pkg;

  localparam int FRAME_LEN      = 8;
  localparam int OP_W           = 4;
  localparam int ADD_PHASE_LAST = 3;

  // Generator position that corresponds to frame position k = 0.
  localparam logic [2:0] POS_FIRST   = 3'd1;
  localparam logic [2:0] K_LAST      = 3'(FRAME_LEN - 1);
  localparam logic [2:0] K_SUB_FIRST = 3'(ADD_PHASE_LAST + 1);

  typedef enum logic [0:0] {
    FR_IDLE   = 1'b0,
    FR_ACTIVE = 1'b1
  } frame_state_t;

  // k = (CTRL_IN_B - 1) mod 8; the 3-bit wrap provides the modulo.
  function automatic logic [2:0] pos_to_k(input logic [2:0] pos);
    return pos - POS_FIRST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// ============================================================================
// Module   : serial_fa_bit
// Purpose  : 1-bit full adder with optional inversion of the B input, shared
//            by the add phase (no inversion) and the subtract phase (B
//            inverted, carry seeded with 1 to form two's complement).
// Ports    : i_a, i_b    - operand bits
//            i_inv_b     - invert i_b before adding
//            i_cin       - carry in
//            o_s, o_cout - sum bit and carry out
// Revision : 1.0 - initial release
// ============================================================================
module serial_fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_inv_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_b;

  assign w_b    = i_b ^ i_inv_b;
  assign o_s    = i_a ^ w_b ^ i_cin;
  assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

endmodule
`default_nettype wire

// File: rtl/serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_unit
// Purpose  : Bit-serial 4-bit adder/subtractor driven by an external
//            control-signal generator. An 8-cycle frame computes A+B LSB
//            first in positions 0..3 and A-B in positions 4..7 through one
//            shared full adder. Results are published at frame end with a
//            one-cycle RES_VALID pulse. An optional checker flags (sticky)
//            any malformed generator sequence and aborts the frame in flight.
// Ports    : CLK, RST         - clock, synchronous active-high reset
//            CARRY_IN         - carry seed from generator
//            CTRL_IN_A        - 1 = add phase, 0 = subtract phase
//            CTRL_IN_B[2:0]   - frame position 1,2,...,7,0
//            OP_A, OP_B       - operands, OP_VALID offers them
//            OP_READY         - operands accepted this cycle if OP_VALID
//            SUM, DIFF        - A+B, A-B (mod 16)
//            COUT, NBORROW    - add carry-out, subtract carry-out (A>=B)
//            RES_VALID        - one-cycle pulse on result update
//            SEQ_ERR          - sticky control-sequence violation
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_unit
  import serial_addsub_unit_pkg::*;
#(
  parameter int CHECK_EN = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CARRY_IN,
  input  logic            CTRL_IN_A,
  input  logic [2:0]      CTRL_IN_B,
  input  logic [OP_W-1:0] OP_A,
  input  logic [OP_W-1:0] OP_B,
  input  logic            OP_VALID,
  output logic            OP_READY,
  output logic [OP_W-1:0] SUM,
  output logic [OP_W-1:0] DIFF,
  output logic            COUT,
  output logic            NBORROW,
  output logic            RES_VALID,
  output logic            SEQ_ERR
);

  // --------------------------------------------------------------------------
  // Position decode
  // --------------------------------------------------------------------------
  logic [2:0] w_k;
  logic [1:0] w_bit;
  logic       w_add;
  logic       w_accept;

  assign w_k      = pos_to_k(CTRL_IN_B);
  assign w_bit    = w_k[1:0];
  assign w_add    = (w_k <= 3'(ADD_PHASE_LAST));
  assign OP_READY = (CTRL_IN_B == POS_FIRST) && !RST;
  assign w_accept = OP_VALID & OP_READY;

  // --------------------------------------------------------------------------
  // Sequence checker
  // --------------------------------------------------------------------------
  logic [2:0] r_prev_b;
  logic       r_prev_valid;   // low for the first cycle after reset
  logic       w_inc_bad;
  logic       w_phase_bad;
  logic       w_carry_bad;
  logic       w_viol;

  assign w_inc_bad   = r_prev_valid && (CTRL_IN_B != (r_prev_b + 3'd1));
  assign w_phase_bad = (CTRL_IN_A != w_add);
  assign w_carry_bad = (CARRY_IN != ~CTRL_IN_A);
  assign w_viol      = (CHECK_EN != 0) && (w_inc_bad || w_phase_bad || w_carry_bad);

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  frame_state_t r_state;
  frame_state_t w_state_nxt;
  logic         w_in_frame;   // this cycle contributes a result bit
  logic         w_complete;   // last bit of an error-free frame

  always_comb begin
    w_state_nxt = r_state;
    w_in_frame  = 1'b0;
    w_complete  = 1'b0;
    if (w_viol) begin
      // A violation kills whatever is in flight, including a same-cycle accept.
      w_state_nxt = FR_IDLE;
    end else if (w_accept) begin
      w_state_nxt = FR_ACTIVE;
      w_in_frame  = 1'b1;
    end else if (r_state == FR_ACTIVE) begin
      w_in_frame = 1'b1;
      if (w_k == K_LAST) begin
        w_complete  = 1'b1;
        w_state_nxt = FR_IDLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shared serial datapath
  // --------------------------------------------------------------------------
  logic [OP_W-1:0] r_a;
  logic [OP_W-1:0] r_b;
  logic            r_carry;
  logic [OP_W-1:0] r_sum_sh;
  logic [OP_W-1:0] r_diff_sh;
  logic            r_add_cout;
  logic            w_fa_a;
  logic            w_fa_b;
  logic            w_fa_cin;
  logic            w_fa_s;
  logic            w_fa_cout;

  // Bit 0 of the add phase comes straight from the ports: operands are
  // only latched at the end of the accept cycle.
  assign w_fa_a   = (w_k == 3'd0) ? OP_A[0] : r_a[w_bit];
  assign w_fa_b   = (w_k == 3'd0) ? OP_B[0] : r_b[w_bit];
  assign w_fa_cin = ((w_k == 3'd0) || (w_k == K_SUB_FIRST)) ? CARRY_IN : r_carry;

  serial_fa_bit u_fa (
    .i_a     (w_fa_a),
    .i_b     (w_fa_b),
    .i_inv_b (~w_add),
    .i_cin   (w_fa_cin),
    .o_s     (w_fa_s),
    .o_cout  (w_fa_cout)
  );

  // --------------------------------------------------------------------------
  // State and result registers
  // --------------------------------------------------------------------------
  logic [OP_W-1:0] r_sum;
  logic [OP_W-1:0] r_diff;
  logic            r_cout;
  logic            r_nborrow;
  logic            r_res_valid;
  logic            r_seq_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= FR_IDLE;
      r_prev_b     <= 3'd0;
      r_prev_valid <= 1'b0;
      r_seq_err    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_sum_sh     <= '0;
      r_diff_sh    <= '0;
      r_add_cout   <= 1'b0;
      r_sum        <= '0;
      r_diff       <= '0;
      r_cout       <= 1'b0;
      r_nborrow    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_b     <= CTRL_IN_B;
      r_prev_valid <= 1'b1;
      r_seq_err    <= r_seq_err | w_viol;
      r_res_valid  <= w_complete;

      if (w_accept) begin
        r_a <= OP_A;
        r_b <= OP_B;
      end

      if (w_in_frame) begin
        r_carry <= w_fa_cout;
        // LSB-first: new bits enter at the MSB and shift down.
        if (w_add) begin
          r_sum_sh <= {w_fa_s, r_sum_sh[OP_W-1:1]};
          if (w_k == 3'(ADD_PHASE_LAST)) begin
            r_add_cout <= w_fa_cout;
          end
        end else begin
          r_diff_sh <= {w_fa_s, r_diff_sh[OP_W-1:1]};
        end
      end

      if (w_complete) begin
        r_sum     <= r_sum_sh;
        r_cout    <= r_add_cout;
        r_diff    <= {w_fa_s, r_diff_sh[OP_W-1:1]};
        r_nborrow <= w_fa_cout;
      end
    end
  end

  assign SUM       = r_sum;
  assign DIFF      = r_diff;
  assign COUT      = r_cout;
  assign NBORROW   = r_nborrow;
  assign RES_VALID = r_res_valid;
  assign SEQ_ERR   = r_seq_err;

endmodule
`default_nettype wire

// File: doc/serial_addsub_unit.md
SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

Interface
REQ-001 SHALL have parameter CHECK_EN, default 1, meaning control-sequence checking enabled (0: SEQ_ERR tied low).
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port CARRY_IN  input  1  carry seed from control-signal generator.
REQ-005 SHALL have port CTRL_IN_A  input  1  phase select from generator (1 = add phase, 0 = subtract phase).
REQ-006 SHALL have port CTRL_IN_B  input  3  frame position from generator (1,2,...,7,0 repeating).
REQ-007 SHALL have ports OP_A, OP_B  input  4 each  operands.
REQ-008 SHALL have port OP_VALID  input  1  operands offered.
REQ-009 SHALL have port OP_READY  output  1  operands accepted this cycle if OP_VALID.
REQ-010 SHALL have ports SUM, DIFF  output  4 each  results A+B, A-B (mod 16).
REQ-011 SHALL have ports COUT, NBORROW  output  1 each  add carry-out, subtract carry-out (1 = A>=B).
REQ-012 SHALL have port RES_VALID  output  1  one-cycle pulse, results updated.
REQ-013 SHALL have port SEQ_ERR  output  1  sticky control-sequence violation flag.

Function
REQ-014 Frame = 8 cycles; frame position k = (CTRL_IN_B - 1) mod 8; k=0 at CTRL_IN_B=1.
REQ-015 OP_READY SHALL be combinational: high iff CTRL_IN_B==1 and RST low; accept = OP_VALID & OP_READY.
REQ-016 On accept, OP_A/OP_B SHALL be latched; frame active; no accept -> frame idle, no computation, no RES_VALID.
REQ-017 k=0..3 (add phase): bit i=k; sum[i] = a[i]^b[i]^c; c seeded from CARRY_IN at k=0, else internal carry register.
REQ-018 At k=0 bit 0 SHALL use OP_A/OP_B ports directly (same-cycle accept); later bits use latched operands.
REQ-019 k=4..7 (subtract phase): bit i=k-4; diff[i] = a[i]^~b[i]^c; c seeded from CARRY_IN at k=4.
REQ-020 Partial results SHALL accumulate in internal shift registers; SUM/DIFF/COUT/NBORROW outputs change only on frame completion.
REQ-021 At the edge ending k=7 of an active, error-free frame, outputs SHALL update and RES_VALID SHALL be high the following cycle only.
REQ-022 Results SHALL hold until next completed frame; back-to-back frames SHALL give one RES_VALID per frame, 8 cycles apart.
REQ-023 Check (CHECK_EN=1): each cycle CTRL_IN_B SHALL equal previous+1 mod 8, CTRL_IN_A SHALL equal (CTRL_IN_B in 1..4), CARRY_IN SHALL equal ~CTRL_IN_A.
REQ-024 Increment check SHALL be skipped on first cycle after reset (no previous value).
REQ-025 Violation SHALL set SEQ_ERR the following cycle, abort the active frame (no RES_VALID), resume accepting at next CTRL_IN_B==1.
REQ-026 SEQ_ERR SHALL clear only on reset.

Reset
REQ-027 While RST high: SUM=0, DIFF=0, COUT=0, NBORROW=0, RES_VALID=0, SEQ_ERR=0, OP_READY=0, frame idle, carry=0.
REQ-028 Reset mid-frame SHALL discard the frame; first cycle after reset is unchecked position reference.

Structure
REQ-029 Shared package SHALL hold FRAME_LEN=8, OP_W=4, ADD_PHASE_LAST=3 and the CTRL_IN_B->k mapping constant.
REQ-030 One sub-module serial_fa_bit (1-bit full adder with optional B inversion) SHALL be instantiated once, shared by both phases.
REQ-031 Everything else (frame tracking, checker, result registers) SHALL be in the top module; no async logic.

Verification
REQ-032 Generator-driven, A=5,B=3 accepted at CTRL_IN_B=1 -> 8 cycles later RES_VALID, SUM=8, COUT=0, DIFF=2, NBORROW=1.
REQ-033 A=9,B=12 -> SUM=5, COUT=1, DIFF=13, NBORROW=0.
REQ-034 OP_VALID low at CTRL_IN_B=1 -> no RES_VALID that frame, previous results unchanged.
REQ-035 CTRL_IN_B jumps 3->5 mid-frame -> SEQ_ERR high next cycle and stays; frame aborted; next frame A=1,B=1 -> SUM=2, DIFF=0, NBORROW=1.
REQ-036 RST pulsed at k=5 -> all outputs 0, no RES_VALID; next accepted frame completes normally.
REQ-037 Three back-to-back frames (A,B)=(15,1),(0,1),(7,7) -> RES_VALID every 8 cycles, SUM=0/1/14, COUT=1/0/0, DIFF=14/15/0, NBORROW=1/0/1.
